// File: rtl/wash_pkg.sv
// Shared state/phase encoding for the wash sequencer and the panel display logic.
package wash_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FILL      = 4'd1,
        ST_DETERGENT = 4'd2,
        ST_AGITATE   = 4'd3,
        ST_DRAIN     = 4'd4,
        ST_SPIN      = 4'd5,
        ST_DONE      = 4'd6,
        ST_FAULT     = 4'd7
    } wash_state_t;

    localparam logic [3:0] PHASE_IDLE      = 4'd0;
    localparam logic [3:0] PHASE_FILL      = 4'd1;
    localparam logic [3:0] PHASE_DETERGENT = 4'd2;
    localparam logic [3:0] PHASE_AGITATE   = 4'd3;
    localparam logic [3:0] PHASE_DRAIN     = 4'd4;
    localparam logic [3:0] PHASE_SPIN      = 4'd5;
    localparam logic [3:0] PHASE_DONE      = 4'd6;
    localparam logic [3:0] PHASE_FAULT     = 4'd7;

    // States in which the tub holds the door locked and Pause can freeze the program.
    function automatic logic is_running(input wash_state_t s);
        return (s == ST_FILL) || (s == ST_DETERGENT) || (s == ST_AGITATE) ||
               (s == ST_DRAIN) || (s == ST_SPIN);
    endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Tick-driven saturating phase timer; flags the Tick on which the current state has
// spent exactly 'limit' Ticks (a limit of 0 behaves as 1).
module wash_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clear,
    input  logic             tick,
    input  logic             freeze,
    input  logic [CNT_W-1:0] limit,
    output logic             reached
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last_count;

    assign last_count = (limit == '0) ? '0 : limit - CNT_W'(1);
    assign reached    = tick && !freeze && (count == last_count);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && !freeze && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wash_cycle_controller.sv
// Washing-machine sequencer: fill, detergent, wash, N rinses, drain, spin, with pause,
// abort-with-drain and fill/drain watchdogs. All outputs are registered from the next state.
module wash_cycle_controller #(
    parameter int CNT_W       = 16,
    parameter int WASH_TICKS  = 1000,
    parameter int RINSE_TICKS = 500,
    parameter int SPIN_TICKS  = 300,
    parameter int FILL_LIMIT  = 2000,
    parameter int DRAIN_LIMIT = 2000,
    parameter int RINSE_W     = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Tick,
    input  logic               Start,
    input  logic               Door_Close,
    input  logic               Filled,
    input  logic               Drained,
    input  logic               Detergent_Added,
    input  logic               Pause,
    input  logic               Abort,
    input  logic [RINSE_W-1:0] Rinse_Count,
    output logic               Motor_on,
    output logic               Spin_fast,
    output logic               Fill_valve_on,
    output logic               Drained_valve_on,
    output logic               Door_Lock,
    output logic               Done,
    output logic               Fault,
    output logic [3:0]         Phase
);

    import wash_pkg::*;

    localparam logic [CNT_W-1:0] WASH_L  = CNT_W'(WASH_TICKS);
    localparam logic [CNT_W-1:0] RINSE_L = CNT_W'(RINSE_TICKS);
    localparam logic [CNT_W-1:0] SPIN_L  = CNT_W'(SPIN_TICKS);
    localparam logic [CNT_W-1:0] FILL_L  = CNT_W'(FILL_LIMIT);
    localparam logic [CNT_W-1:0] DRAIN_L = CNT_W'(DRAIN_LIMIT);

    wash_state_t        state;
    wash_state_t        next_state;
    logic               abort_flag;
    logic [RINSE_W:0]   pass;
    logic [RINSE_W-1:0] rinse_latched;
    logic               aborting;
    logic               paused;
    logic               out_paused;
    logic               timer_clear;
    logic               reached;
    logic [CNT_W-1:0]   limit;

    // Once an abort is pending, Pause no longer holds anything back.
    assign aborting    = Abort || abort_flag;
    assign paused      = Pause && is_running(state) && !aborting;
    assign out_paused  = Pause && is_running(next_state) && !aborting;
    assign timer_clear = (next_state != state);

    always_comb begin
        limit = '1;
        case (state)
            ST_FILL:    limit = FILL_L;
            ST_AGITATE: limit = (pass == '0) ? WASH_L : RINSE_L;
            ST_DRAIN:   limit = DRAIN_L;
            ST_SPIN:    limit = SPIN_L;
            default:    limit = '1;
        endcase
    end

    wash_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .clear   (timer_clear),
        .tick    (Tick),
        .freeze  (paused),
        .limit   (limit),
        .reached (reached)
    );

    // Sensors are tested before the watchdog so a late Filled/Drained still wins.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (Start && Door_Close) next_state = ST_FILL;
            end
            ST_FILL: begin
                if (Abort) next_state = ST_DRAIN;
                else if (!paused) begin
                    if (Filled) next_state = (pass == '0) ? ST_DETERGENT : ST_AGITATE;
                    else if (reached) next_state = ST_FAULT;
                end
            end
            ST_DETERGENT: begin
                if (Abort) next_state = ST_DRAIN;
                else if (!paused && Detergent_Added) next_state = ST_AGITATE;
            end
            ST_AGITATE: begin
                if (Abort) next_state = ST_DRAIN;
                else if (reached) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!paused && Drained) begin
                    if (aborting) next_state = ST_IDLE;
                    else if (pass < {1'b0, rinse_latched}) next_state = ST_FILL;
                    else next_state = ST_SPIN;
                end else if (reached) begin
                    next_state = ST_FAULT;
                end
            end
            ST_SPIN: begin
                if (Abort) next_state = ST_DRAIN;
                else if (reached) next_state = ST_DONE;
            end
            ST_DONE:  next_state = ST_IDLE;
            ST_FAULT: begin
                if (Abort && Drained) next_state = ST_IDLE;
            end
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state            <= ST_IDLE;
            abort_flag       <= 1'b0;
            pass             <= '0;
            rinse_latched    <= '0;
            Motor_on         <= 1'b0;
            Spin_fast        <= 1'b0;
            Fill_valve_on    <= 1'b0;
            Drained_valve_on <= 1'b0;
            Door_Lock        <= 1'b0;
            Done             <= 1'b0;
            Fault            <= 1'b0;
            Phase            <= PHASE_IDLE;
        end else begin
            state <= next_state;

            if (next_state == ST_IDLE) abort_flag <= 1'b0;
            else if (Abort && (state != ST_IDLE)) abort_flag <= 1'b1;

            if ((state == ST_IDLE) && (next_state == ST_FILL)) begin
                pass          <= '0;
                rinse_latched <= Rinse_Count;
            end else if ((state == ST_DRAIN) && (next_state == ST_FILL)) begin
                pass <= pass + 1'b1;
            end

            Motor_on         <= ((next_state == ST_AGITATE) || (next_state == ST_SPIN)) && !out_paused;
            Spin_fast        <= (next_state == ST_SPIN) && !out_paused;
            Fill_valve_on    <= (next_state == ST_FILL) && !out_paused;
            Drained_valve_on <= (((next_state == ST_DRAIN) || (next_state == ST_SPIN)) && !out_paused) ||
                                (next_state == ST_FAULT);
            Door_Lock        <= is_running(next_state) || ((next_state == ST_FAULT) && !Drained);
            Done             <= (next_state == ST_DONE);
            Fault            <= (next_state == ST_FAULT);
            Phase            <= next_state;
        end
    end

endmodule
